nes_multi_pad_reader: RTL
=========================

Name: nes_multi_pad_reader

Overview:
Parametrised successor to the single-pad NES reader. It polls NUM_PADS NES controllers in parallel on a shared latch/clock pair, with one serial data line per pad. Each pad's button byte is debounced across consecutive frames, and one-cycle pressed/released edge pulses are generated per button. It feeds the top level, replacing the per-button wires to the VGA, clock-driver and audio blocks.

Parameters:
NUM_PADS, 2, number of controllers; data lines share latch/pulse.
POLL_CYCLES, 833333, clock cycles between frame starts (60 Hz at 50 MHz).
LATCH_CYCLES, 600, latch high time (12 us at 50 MHz).
HALF_CYCLES, 300, half period of pad clock (6 us); must be >= 4.
DEBOUNCE_FRAMES, 2, consecutive identical raw frames required before commit (1 = commit every frame).

Ports:
clock  input  1  system clock, 50 MHz.
reset_n  input  1  asynchronous, active-low reset.
enable  input  1  high = start new frames on poll tick.
data_in  input  NUM_PADS  serial data from each pad, active-low (0 = pressed).
latch  output  1  shared pad latch, active-high.
pulse  output  1  shared pad clock, idle low.
buttons  output  8*NUM_PADS  debounced state, active-high; pad p bits [8p+7:8p] = {Right,Left,Down,Up,Start,Select,B,A}.
pressed  output  8*NUM_PADS  one-cycle pulse per button on 0->1 commit.
released  output  8*NUM_PADS  one-cycle pulse per button on 1->0 commit.
frame_done  output  1  one-cycle pulse at end of every frame.

Behaviour:
- Reset (async, while reset_n low): latch=0, pulse=0, buttons=0, pressed=0, released=0, frame_done=0; poll counter, debounce counters, raw/previous registers = 0; FSM=IDLE. Asserting reset mid-frame drops latch/pulse immediately; the partial frame is discarded.
- data_in passes through a 2-FF synchroniser per pad. Samples are taken from the synchronised value.
- Poll counter: free-running 0..POLL_CYCLES-1, wraps. Tick = counter == POLL_CYCLES-1.
- FSM states:
  - IDLE: on tick with enable=1 -> LATCH. Ticks in any other state, or with enable=0, are ignored.
  - LATCH: latch=1 for LATCH_CYCLES cycles -> LOW with bit index=0.
  - LOW: latch=0, pulse=0 for HALF_CYCLES. On the last cycle, sample all pads' bit[index] = ~data_sync. If index==7 -> DONE, else -> HIGH.
  - HIGH: pulse=1 for HALF_CYCLES; index++ -> LOW.
  - DONE: one cycle. Debounce/commit; frame_done=1 -> IDLE.
- Frame timing: frame length = LATCH_CYCLES + 8*HALF_CYCLES + 7*HALF_CYCLES + 1 cycles. The pad clock produces exactly 7 rising edges per frame. Constraint: frame length < POLL_CYCLES.
- Debounce, per pad, evaluated in DONE:
  - If raw == prev_raw, stable_cnt saturates-increments; else stable_cnt=1 and prev_raw=raw.
  - Commit when stable_cnt >= DEBOUNCE_FRAMES and raw != buttons.
  - On commit, from the cycle after DONE, for exactly 1 cycle: buttons<=raw, pressed<=raw & ~buttons_old, released<=~raw & buttons_old. frame_done is asserted in the same cycle.
  - With no commit, edge outputs stay 0.
- Pads are independent: one pad can commit while another does not in the same frame.
- Disconnected pad (line pulled high) reads all 0s, so no buttons are pressed.
- enable falling mid-frame: the current frame completes normally, including commit. No further frames start.

Test Plan:
- Params POLL=200, LATCH=4, HALF=4, DEBOUNCE=2; reset_n=0 then 1 -> latch first rises at cycle 200 for 4 cycles. There are exactly 7 pulse rising edges, spaced 8 cycles apart. frame_done fires 65 cycles after latch rises.
- Pad0 drives A and Right low (pressed), pad1 idle, for 2 frames -> after frame 2: buttons[7:0]=8'h81, pressed[7:0]=8'h81 for 1 cycle, buttons[15:8]=0. After frame 1: no commit.
- Pad0 alternates 8'h81 / 8'h00 every frame with DEBOUNCE=2 -> buttons never changes; pressed/released stay 0; frame_done pulses every frame.
- Pad0 held at 8'h81, then released for 2 frames -> buttons[7:0]=0, released[7:0]=8'h81 for 1 cycle.
- reset_n pulsed low during HIGH state of bit 3 -> latch/pulse=0 asynchronously. All outputs 0. Next latch occurs at counter 199 after release.
- enable dropped during LATCH -> that frame completes with frame_done. No latch on subsequent ticks. Re-raising enable resumes at the next tick.

Source files
------------

// File: rtl/nes_multi_pad_reader_if.sv
// Controller-side and host-side signal bundle for nes_multi_pad_reader.
// The master drives enable and the serial pad data; the slave (the reader)
// drives the shared latch/pulse pair and the decoded button outputs.
interface nes_multi_pad_reader_if #(
  parameter int unsigned NUM_PADS = 2
);
  logic                    enable;
  logic [NUM_PADS-1:0]     data_in;
  logic                    latch;
  logic                    pulse;
  logic [8*NUM_PADS-1:0]   buttons;
  logic [8*NUM_PADS-1:0]   pressed;
  logic [8*NUM_PADS-1:0]   released;
  logic                    frame_done;

  modport master (
    output enable, data_in,
    input  latch, pulse, buttons, pressed, released, frame_done
  );

  modport slave (
    input  enable, data_in,
    output latch, pulse, buttons, pressed, released, frame_done
  );
endinterface

// File: rtl/nes_multi_pad_reader.sv
// Polls NUM_PADS NES controllers in parallel over a shared latch/pulse pair.
// Each pad's 8-bit button frame is debounced across consecutive frames and
// one-cycle pressed/released pulses are produced on every committed change.
// Bit order per pad (LSB first on the wire): {Right,Left,Down,Up,Start,Select,B,A}.
module nes_multi_pad_reader #(
  parameter int unsigned NUM_PADS        = 2,
  parameter int unsigned POLL_CYCLES     = 833333,
  parameter int unsigned LATCH_CYCLES    = 600,
  parameter int unsigned HALF_CYCLES     = 300,
  parameter int unsigned DEBOUNCE_FRAMES = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  nes_multi_pad_reader_if.slave pad_if
);

  localparam int unsigned POLL_W    = (POLL_CYCLES > 1) ? $clog2(POLL_CYCLES) : 1;
  localparam int unsigned PHASE_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int unsigned TMR_W     = $clog2(PHASE_MAX);
  localparam int unsigned CNT_W     = $clog2(DEBOUNCE_FRAMES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LATCH,
    S_LOW,
    S_HIGH,
    S_DONE
  } state_t;

  // Synchroniser, poll timer and frame sequencer state
  logic [NUM_PADS-1:0] sync_meta_q, sync_q;
  logic [POLL_W-1:0]   poll_q;
  logic                tick;
  state_t              state_q, state_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [2:0]          bit_q, bit_d;
  logic                sample_en;
  logic                latch_q, pulse_q;

  // Per-pad frame capture and debounce state
  logic [NUM_PADS-1:0][7:0]       raw_q;
  logic [NUM_PADS-1:0][7:0]       prev_q;
  logic [NUM_PADS-1:0][CNT_W-1:0] cnt_q;
  logic [NUM_PADS-1:0][CNT_W-1:0] cnt_nxt;
  logic [NUM_PADS-1:0]            commit;
  logic [NUM_PADS-1:0][7:0]       buttons_q, pressed_q, released_q;
  logic                           frame_done_q;

  assign tick = (poll_q == POLL_W'(POLL_CYCLES - 1));

  // Two-stage synchroniser per pad data line; idle line level is high.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours, independent of statement order.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta_q <= '1;
      sync_q      <= '1;
    end else begin
      sync_meta_q <= pad_if.data_in;
      sync_q      <= sync_meta_q;
    end
  end

  // Free-running frame-start timer; wraps regardless of enable or FSM state.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      poll_q <= '0;
    end else if (tick) begin
      poll_q <= '0;
    end else begin
      poll_q <= poll_q + POLL_W'(1);
    end
  end

  // Sequencer state register; latch/pulse are registered from the next state
  // so the pad lines are glitch-free and drop immediately on reset.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      bit_q   <= '0;
      latch_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      bit_q   <= bit_d;
      latch_q <= (state_d == S_LATCH);
      pulse_q <= (state_d == S_HIGH);
    end
  end

  // Sequencer next-state: latch, then 8 low/high pulse halves, then one DONE cycle.
  // NOTE: every signal assigned here gets a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q + TMR_W'(1);
    bit_d     = bit_q;
    sample_en = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        timer_d = '0;
        if (tick && pad_if.enable) state_d = S_LATCH;
      end
      S_LATCH: begin
        if (timer_q == TMR_W'(LATCH_CYCLES - 1)) begin
          timer_d = '0;
          bit_d   = 3'd0;
          state_d = S_LOW;
        end
      end
      S_LOW: begin
        if (timer_q == TMR_W'(HALF_CYCLES - 1)) begin
          timer_d   = '0;
          sample_en = 1'b1;
          state_d   = (bit_q == 3'd7) ? S_DONE : S_HIGH;
        end
      end
      S_HIGH: begin
        if (timer_q == TMR_W'(HALF_CYCLES - 1)) begin
          timer_d = '0;
          bit_d   = bit_q + 3'd1;
          state_d = S_LOW;
        end
      end
      S_DONE: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        timer_d = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  // Capture the current bit of every pad at the end of each low half (active-low line).
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      raw_q <= '0;
    end else if (sample_en) begin
      for (int p = 0; p < NUM_PADS; p++) begin
        raw_q[p][bit_q] <= ~sync_q[p];
      end
    end
  end

  // Debounce evaluation: stability count for this frame and per-pad commit decision.
  always_comb begin
    cnt_nxt = cnt_q;
    commit  = '0;
    for (int p = 0; p < NUM_PADS; p++) begin
      if (raw_q[p] == prev_q[p]) begin
        if (cnt_q[p] < CNT_W'(DEBOUNCE_FRAMES)) cnt_nxt[p] = cnt_q[p] + CNT_W'(1);
      end else begin
        cnt_nxt[p] = CNT_W'(1);
      end
      commit[p] = (cnt_nxt[p] >= CNT_W'(DEBOUNCE_FRAMES)) && (raw_q[p] != buttons_q[p]);
    end
  end

  // Debounce bookkeeping and committed outputs; edge pulses last one cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      prev_q       <= '0;
      cnt_q        <= '0;
      buttons_q    <= '0;
      pressed_q    <= '0;
      released_q   <= '0;
      frame_done_q <= 1'b0;
    end else begin
      pressed_q    <= '0;
      released_q   <= '0;
      frame_done_q <= (state_q == S_DONE);
      if (state_q == S_DONE) begin
        prev_q <= raw_q;
        cnt_q  <= cnt_nxt;
        for (int p = 0; p < NUM_PADS; p++) begin
          if (commit[p]) begin
            buttons_q[p]  <= raw_q[p];
            pressed_q[p]  <= raw_q[p] & ~buttons_q[p];
            released_q[p] <= ~raw_q[p] & buttons_q[p];
          end
        end
      end
    end
  end

  assign pad_if.latch      = latch_q;
  assign pad_if.pulse      = pulse_q;
  assign pad_if.buttons    = buttons_q;
  assign pad_if.pressed    = pressed_q;
  assign pad_if.released   = released_q;
  assign pad_if.frame_done = frame_done_q;

endmodule
